// File: rtl/mult_seq_param.sv
// Sequential shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH, signed or unsigned, start/busy/done handshake.
// Define MULT_EARLY_TERM_EN to leave WORK as soon as the remaining multiplier bits are all zero.
module mult_seq_param #(
  parameter int WIDTH = 32
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     lhs,
  input  logic [WIDTH-1:0]     rhs,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WORK = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         r_state;
  logic               r_neg;
  logic [WIDTH-1:0]   r_mplr;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_result;
  logic               r_busy;
  logic               r_done;

  logic [WIDTH-1:0]   w_lhs_mag;
  logic [WIDTH-1:0]   w_rhs_mag;
  logic [WIDTH-1:0]   w_mplr_next;
  logic [2*WIDTH-1:0] w_acc_next;
  logic               w_last_cnt;
  logic               w_last;

  // Magnitudes in WIDTH-bit unsigned, so the most-negative operand maps to 2^(WIDTH-1) exactly.
  assign w_lhs_mag   = (is_signed && lhs[WIDTH-1]) ? -lhs : lhs;
  assign w_rhs_mag   = (is_signed && rhs[WIDTH-1]) ? -rhs : rhs;
  assign w_mplr_next = r_mplr >> 1;
  assign w_acc_next  = r_mplr[0] ? (r_acc + r_mcand) : r_acc;
  assign w_last_cnt  = (r_cnt == CW'(WIDTH - 1));

`ifdef MULT_EARLY_TERM_EN
  assign w_last = w_last_cnt || (w_mplr_next == '0);
`else
  assign w_last = w_last_cnt;
`endif

  // NOTE: every register, datapath included, is cleared by reset so an aborted
  // operation leaves no trace; all state updates use non-blocking assignments.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_neg    <= 1'b0;
      r_mplr   <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_neg   <= is_signed & (lhs[WIDTH-1] ^ rhs[WIDTH-1]);
            r_mplr  <= w_lhs_mag;
            r_mcand <= {{WIDTH{1'b0}}, w_rhs_mag};
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_WORK;
          end
        end
        S_WORK: begin
          r_acc   <= w_acc_next;
          r_mcand <= r_mcand << 1;
          r_mplr  <= w_mplr_next;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) r_state <= S_FIX;
        end
        S_FIX: begin
          r_result <= r_neg ? -r_acc : r_acc;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign result = r_result;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_mult_seq_param.sv
// Scoreboard bench for mult_seq_param: a 32-bit and an 8-bit instance, directed corner cases plus random operands.
module tb_mult_seq_param;

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

`ifdef MULT_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        reset = 1'b1;

  logic        start32 = 1'b0, sgn32 = 1'b0;
  logic [31:0] lhs32 = '0, rhs32 = '0;
  logic [63:0] res32;
  logic        busy32, done32;

  logic        start8 = 1'b0, sgn8 = 1'b0;
  logic [7:0]  lhs8 = '0, rhs8 = '0;
  logic [15:0] res8;
  logic        busy8, done8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t q32[$];
  exp_t q8[$];
  int lo32 = 1, hi32 = 0, lo8 = 1, hi8 = 0;
  logic [63:0] hold32 = '0;
  logic [63:0] hold8 = '0;

  mult_seq_param #(.WIDTH(32)) u_dut32 (
    .Clk(Clk), .reset(reset), .start(start32), .is_signed(sgn32),
    .lhs(lhs32), .rhs(rhs32), .result(res32), .busy(busy32), .done(done32)
  );

  mult_seq_param #(.WIDTH(8)) u_dut8 (
    .Clk(Clk), .reset(reset), .start(start8), .is_signed(sgn8),
    .lhs(lhs8), .rhs(rhs8), .result(res8), .busy(busy8), .done(done8)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] wmask(input int w);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Reference product: interpret operands as w-bit integers, multiply, keep 2w bits.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic s, input int w);
    longint va, vb;
    logic [63:0] m2;
    va = longint'(a & wmask(w));
    vb = longint'(b & wmask(w));
    if (s && a[w-1]) va -= longint'(1) << w;
    if (s && b[w-1]) vb -= longint'(1) << w;
    m2 = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    return 64'(va * vb) & m2;
  endfunction

  // Number of WORK cycles: WIDTH, or highest set bit of |lhs| + 1 with early termination.
  function automatic int work_cycles(input logic [31:0] a, input logic s, input int w);
    logic [31:0] m;
    int l;
    m = a & wmask(w);
    if (s && a[w-1]) m = (~m + 32'd1) & wmask(w);
    l = 1;
    for (int i = 0; i < w; i++) if (m[i]) l = i + 1;
    return ET ? l : w;
  endfunction

  always @(posedge Clk) begin : mon32
    exp_t e;
    #1;
    check("busy32", 64'(busy32), 64'(cyc >= lo32 && cyc <= hi32));
    if (done32) begin
      if (q32.size() == 0) check("spurious_done32", 64'(done32), 64'd0);
      else begin
        e = q32.pop_front();
        check("result32", res32, e.res);
        check("done_cycle32", 64'(cyc), 64'(e.cyc));
        hold32 = res32;
      end
    end else if (q32.size() > 0 && cyc > q32[0].cyc) begin
      check("timeout32", 64'(done32), 64'd1);
      void'(q32.pop_front());
    end
    check("hold32", res32, hold32);
  end

  always @(posedge Clk) begin : mon8
    exp_t e;
    #1;
    check("busy8", 64'(busy8), 64'(cyc >= lo8 && cyc <= hi8));
    if (done8) begin
      if (q8.size() == 0) check("spurious_done8", 64'(done8), 64'd0);
      else begin
        e = q8.pop_front();
        check("result8", 64'(res8), e.res);
        check("done_cycle8", 64'(cyc), 64'(e.cyc));
        hold8 = 64'(res8);
      end
    end else if (q8.size() > 0 && cyc > q8[0].cyc) begin
      check("timeout8", 64'(done8), 64'd1);
      void'(q8.pop_front());
    end
    check("hold8", 64'(res8), hold8);
  end

  // One 32-bit operation; poke_at re-pulses start in that WORK cycle, rst_at aborts with reset.
  task automatic go32(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [63:0] exp, input int poke_at, input int rst_at);
    int l, cb;
    l = work_cycles(a, s, 32);
    @(negedge Clk);
    lhs32 = a; rhs32 = b; sgn32 = s; start32 = 1'b1;
    cb = cyc;
    q32.push_back('{res: exp, cyc: cb + l + 2});
    lo32 = cb + 1;
    hi32 = cb + l + 1;
    @(negedge Clk);
    start32 = 1'b0; lhs32 = $urandom; rhs32 = $urandom; sgn32 = 1'($urandom);
    for (int k = 1; k < l + 2; k++) begin
      start32 = (k == poke_at);
      if (k == poke_at) begin lhs32 = 32'd2; rhs32 = 32'd2; end
      if (k == rst_at) begin
        reset = 1'b1;
        q32.delete();
        q8.delete();
        hi32 = cyc;
        hi8 = cyc;
        hold32 = '0;
        hold8 = '0;
        @(negedge Clk);
        reset = 1'b0;
        return;
      end
      @(negedge Clk);
    end
    start32 = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge Clk);
  endtask

  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [15:0] exp);
    int l, cb;
    l = work_cycles(32'(a), s, 8);
    @(negedge Clk);
    lhs8 = a; rhs8 = b; sgn8 = s; start8 = 1'b1;
    cb = cyc;
    q8.push_back('{res: 64'(exp), cyc: cb + l + 2});
    lo8 = cb + 1;
    hi8 = cb + l + 1;
    @(negedge Clk);
    start8 = 1'b0; lhs8 = 8'($urandom); rhs8 = 8'($urandom); sgn8 = 1'($urandom);
    repeat (l + 1 + $urandom_range(1, 3)) @(negedge Clk);
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] a, b;
    logic [7:0]  a8, b8;
    logic        s;
    repeat (3) @(negedge Clk);
    reset = 1'b0;

    go32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0, 0);
    go32(32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 0, 0);
    go32(32'hFFFF_FFFD, 32'd7, 1'b0, 64'h0000_0006_FFFF_FFEB, 0, 0);
    go32(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 0, 0);
    go32(32'h8000_0000, 32'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, 0, 0);
    go32(32'd5, 32'd9, 1'b0, 64'd45, 10, 0);
    go32(32'd1234, 32'd5678, 1'b0, 64'd7006652, 0, 15);
    go32(32'd1234, 32'd5678, 1'b0, 64'd7006652, 0, 0);
    go32(32'd3, 32'd5, 1'b0, 64'd15, 0, 0);
    go32(32'd0, 32'hDEAD_BEEF, 1'b1, 64'd0, 0, 0);
    go8(8'h81, 8'h02, 1'b1, 16'hFF02);
    go8(8'h80, 8'h80, 1'b1, 16'h4000);
    go8(8'hFF, 8'hFF, 1'b0, 16'hFE01);

    for (int i = 0; i < 12; i++) begin
      a = pick32(); b = pick32(); s = 1'($urandom);
      go32(a, b, s, ref_prod(a, b, s, 32), ($urandom_range(0, 3) == 0) ? 5 : 0, 0);
    end
    for (int i = 0; i < 12; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); s = 1'($urandom);
      go8(a8, b8, s, ref_prod(32'(a8), 32'(b8), s, 8)[15:0]);
    end

    repeat (5) @(negedge Clk);
    check("q32_drained", 64'(q32.size()), 64'd0);
    check("q8_drained", 64'(q8.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_seq_param.md
Name: mult_seq_param

Overview:
- Parametrised sequential shift-add multiplier; successor to the fixed 32-bit, state-driven multiplier in the datapath.
- Adds generic operand width, signed/unsigned mode and a self-contained start/busy/done handshake, so no external FSM state encoding is needed.
- Sits beside the ALU and feeds the HI/LO registers for MULT/MULTU.

Parameters:
- WIDTH, 32, operand width in bits; legal range >= 2; result is 2*WIDTH bits.

Ports:
- Clk  input  1  clock; all logic updates on the rising edge.
- reset  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only in IDLE.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- lhs  input  WIDTH  multiplier operand; sampled with start.
- rhs  input  WIDTH  multiplicand operand; sampled with start.
- result  output  2*WIDTH  product; valid from the done cycle, held until the next accepted start.
- busy  output  1  high from the cycle after start is accepted through the FIX cycle.
- done  output  1  single-cycle pulse when result becomes valid.

Behaviour:
- Reset (synchronous, reset high at a rising edge):
  - state=IDLE; result=0; busy=0; done=0; counter=0; internal registers=0.
  - Reset wins over every other input, including mid-operation. The in-flight operation is discarded and no done pulse is produced.
- States: IDLE, WORK, FIX, DONE.
- IDLE:
  - done=0, busy=0.
  - If start=1 at edge E0: latch neg = is_signed & (lhs[MSB] ^ rhs[MSB]).
  - Multiplier register mplr = |lhs| if signed, else lhs.
  - Multiplicand register mcand (2*WIDTH bits) = zero-extended |rhs| if signed, else rhs.
  - Accumulator acc=0, counter=0, then go to WORK.
  - result is NOT cleared at start; it holds the previous value until FIX.
- Magnitude rule: |x| = -x when x[MSB]=1, computed in WIDTH bits unsigned. The most-negative value 2^(WIDTH-1) is therefore represented exactly.
- WORK (one multiplier bit per cycle):
  - If mplr[0]=1, acc += mcand (2*WIDTH-bit add, no overflow possible).
  - mcand <<= 1; mplr >>= 1; counter += 1.
  - When counter reaches WIDTH-1 on this edge (i.e. the WIDTH-th WORK cycle), go to FIX.
  - counter width is clog2(WIDTH)+1.
- FIX:
  - result = neg ? -acc : acc (2*WIDTH-bit two's complement).
  - done=1 registered on this edge; go to DONE.
- DONE: done=1 for exactly this one cycle, busy=0; next edge returns to IDLE with done=0.
- Latency: start sampled at E0 -> done=1 and result valid after edge E0+WIDTH+1. Minimum start-to-start spacing is WIDTH+3 cycles.
- Ignored inputs:
  - start in WORK/FIX/DONE is ignored and is not queued.
  - lhs, rhs and is_signed changes after E0 have no effect.
- Zero operands: no special case without the optional feature; result=0 with full latency.

Optional Feature:
- Macro MULT_EARLY_TERM_EN.
- Defined:
  - In WORK, if the shifted mplr value becomes 0 on the current edge, go directly to FIX regardless of counter. Result is identical to the full-length run.
  - If |lhs|=0 at start, IDLE goes to WORK and exits after 1 cycle.
  - Latency becomes (index of highest set bit of |lhs|)+1 WORK cycles + FIX; minimum done at E0+2.
- Undefined: fixed WIDTH WORK cycles, as described above.

Test Plan:
1. WIDTH=32, unsigned, lhs=0xFFFFFFFF, rhs=0xFFFFFFFF, start at E0 -> done pulse of exactly 1 cycle after E0+33; result=0xFFFFFFFE00000001; busy high for 33 cycles.
2. Signed, lhs=0xFFFFFFFD (-3), rhs=7 -> result=0xFFFFFFFFFFFFFFEB. Then unsigned with the same operands -> result=0x00000006FFFFFFEB.
3. Signed, lhs=rhs=0x80000000 -> result=0x4000000000000000. Signed, lhs=0x80000000, rhs=1 -> result=0xFFFFFFFF80000000.
4. Start lhs=5, rhs=9; pulse start again at WORK cycle 10 with lhs=2, rhs=2 -> second start ignored; result=45; exactly one done pulse.
5. Start lhs=1234, rhs=5678; assert reset at WORK cycle 15 -> next cycle result=0, busy=0, done=0, state IDLE. A new start then gives 7006652 with normal latency.
6. WIDTH=8 instance, signed, lhs=0x81 (-127), rhs=0x02 -> done after E0+9, result=0xFF02. With MULT_EARLY_TERM_EN, unsigned lhs=3, rhs=5 at WIDTH=32 -> done after E0+3, result=15.
